// File: rtl/udma_read_ctrl.sv
// ---------------------------------------------------------------------------
// udma_read_ctrl
//   Host-side Ultra-DMA data-in sequencer for one burst on the IDE port.
//   Drives the DMACK-/STOP/HDMARDY- envelope, enables the downstream
//   IORDY-edge capture stage, and counts its captured-word pulses until the
//   requested length. It pauses the device when the downstream buffer is
//   nearly full. It handles host-initiated termination (count reached or
//   timeout) and device-initiated termination (DMARQ dropped).
//
// Ports
//   clk              system clock
//   pRST             synchronous, active-high reset
//   start            1-cycle pulse, begin a burst (ignored while busy)
//   xfer_words       number of 16-bit words to read, sampled on start
//   DMARQ            device DMA request, asynchronous
//   word_strobe      1-cycle pulse per word captured downstream
//   buf_almost_full  downstream buffer nearly full, pause the device
//   DMACK_n          DMA acknowledge, active low
//   STOP             host stop (DIOW- pin), 1 = asserted
//   HDMARDY_n        host ready (DIOR- pin), active low
//   IDE_r_en         enables word capture in the downstream stage
//   busy             burst in progress
//   done             1-cycle pulse at burst end
//   short_xfer       with done: device ended before xfer_words
//   err_timeout      with done: burst aborted by the progress timer
//   words_done       words counted this burst, held until the next start
// ---------------------------------------------------------------------------
module udma_read_ctrl #(
    parameter int CNT_W   = 16,
    parameter int T_ENV   = 4,
    parameter int T_LI    = 8,
    parameter int TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             pRST,
    input  logic             start,
    input  logic [CNT_W-1:0] xfer_words,
    input  logic             DMARQ,
    input  logic             word_strobe,
    input  logic             buf_almost_full,
    output logic             DMACK_n,
    output logic             STOP,
    output logic             HDMARDY_n,
    output logic             IDE_r_en,
    output logic             busy,
    output logic             done,
    output logic             short_xfer,
    output logic             err_timeout,
    output logic [CNT_W-1:0] words_done
);

    localparam int TMR_W    = $clog2(TIMEOUT + 1);
    localparam int HOLD_MAX = (T_ENV > T_LI) ? T_ENV : T_LI;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_WAIT_RQ = 4'd1;
    localparam logic [3:0] S_ACK     = 4'd2;
    localparam logic [3:0] S_XFER    = 4'd3;
    localparam logic [3:0] S_PAUSE   = 4'd4;
    localparam logic [3:0] S_HTERM   = 4'd5;
    localparam logic [3:0] S_DTERM   = 4'd6;
    localparam logic [3:0] S_REL     = 4'd7;
    localparam logic [3:0] S_END     = 4'd8;

    logic [3:0]       state_q, state_d;
    logic             dmarq_meta_q, dmarq_s_q;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] xfer_q, xfer_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             dmack_n_q, dmack_n_d;
    logic             stop_q, stop_d;
    logic             hdmardy_n_q, hdmardy_n_d;
    logic             r_en_q, r_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             short_q, short_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] words_inc;
    logic [TMR_W-1:0] timer_step;
    logic             tmr_hit;

    // Word count including this cycle's strobe, saturating at all-ones.
    assign words_inc  = (word_strobe && (words_q != '1)) ? words_q + CNT_W'(1) : words_q;
    // Progress timer: a strobe restarts it, otherwise it advances by one.
    assign timer_step = word_strobe ? '0 : timer_q + TMR_W'(1);
    // This cycle completes TIMEOUT cycles without progress.
    assign tmr_hit    = (timer_q == TMR_W'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no
        // path through the case below can leave one unassigned (no latches).
        state_d     = state_q;
        timer_d     = timer_q;
        hold_d      = hold_q;
        xfer_d      = xfer_q;
        words_d     = words_q;
        dmack_n_d   = dmack_n_q;
        stop_d      = stop_q;
        hdmardy_n_d = hdmardy_n_q;
        r_en_d      = r_en_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        short_d     = short_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xfer_d  = xfer_words;
                    words_d = '0;
                    short_d = 1'b0;
                    err_d   = 1'b0;
                    if (xfer_words == '0) begin
                        done_d = 1'b1;  // empty burst: report at once, pins untouched
                    end else begin
                        state_d = S_WAIT_RQ;
                        busy_d  = 1'b1;
                        timer_d = '0;
                    end
                end
            end

            S_WAIT_RQ: begin
                if (dmarq_s_q) begin
                    state_d   = S_ACK;
                    dmack_n_d = 1'b0;
                    hold_d    = '0;
                end else if (tmr_hit) begin
                    state_d = S_END;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            S_ACK: begin
                if (hold_q == HOLD_W'(T_ENV - 1)) begin
                    state_d     = S_XFER;
                    stop_d      = 1'b0;
                    hdmardy_n_d = 1'b0;
                    r_en_d      = 1'b1;
                    timer_d     = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            S_XFER, S_PAUSE: begin
                words_d = words_inc;
                timer_d = timer_step;
                // Priority: count reached > device drop > timeout > pause control.
                if (words_inc == xfer_q) begin
                    state_d     = S_HTERM;
                    stop_d      = 1'b1;
                    hdmardy_n_d = 1'b1;
                    timer_d     = '0;
                end else if (!dmarq_s_q) begin
                    state_d     = S_DTERM;
                    stop_d      = 1'b1;
                    hdmardy_n_d = 1'b1;
                end else if (!word_strobe && tmr_hit) begin
                    state_d     = S_HTERM;
                    stop_d      = 1'b1;
                    hdmardy_n_d = 1'b1;
                    err_d       = 1'b1;
                    timer_d     = '0;
                end else if ((state_q == S_XFER) && buf_almost_full) begin
                    state_d     = S_PAUSE;
                    hdmardy_n_d = 1'b1;
                end else if ((state_q == S_PAUSE) && !buf_almost_full) begin
                    state_d     = S_XFER;
                    hdmardy_n_d = 1'b0;
                end
            end

            S_HTERM: begin
                // The device may still deliver words in flight; keep counting.
                words_d = words_inc;
                timer_d = timer_step;
                if (!dmarq_s_q) begin
                    state_d = S_REL;
                    hold_d  = '0;
                end else if (!word_strobe && tmr_hit) begin
                    state_d = S_REL;
                    err_d   = 1'b1;
                    hold_d  = '0;
                end
            end

            S_DTERM: begin
                words_d = words_inc;
                short_d = (words_inc < xfer_q);
                state_d = S_REL;
                hold_d  = '0;
            end

            S_REL: begin
                if (hold_q == HOLD_W'(T_LI - 1)) begin
                    state_d   = S_END;
                    dmack_n_d = 1'b1;
                    r_en_d    = 1'b0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            S_END: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make every register sample pre-edge
    // values, so the two-flop DMARQ synchroniser really is two flops deep.
    always_ff @(posedge clk) begin
        if (pRST) begin
            state_q      <= S_IDLE;
            dmarq_meta_q <= 1'b0;
            dmarq_s_q    <= 1'b0;
            timer_q      <= '0;
            hold_q       <= '0;
            xfer_q       <= '0;
            words_q      <= '0;
            dmack_n_q    <= 1'b1;
            stop_q       <= 1'b1;
            hdmardy_n_q  <= 1'b1;
            r_en_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            short_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dmarq_meta_q <= DMARQ;
            dmarq_s_q    <= dmarq_meta_q;
            timer_q      <= timer_d;
            hold_q       <= hold_d;
            xfer_q       <= xfer_d;
            words_q      <= words_d;
            dmack_n_q    <= dmack_n_d;
            stop_q       <= stop_d;
            hdmardy_n_q  <= hdmardy_n_d;
            r_en_q       <= r_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            short_q      <= short_d;
            err_q        <= err_d;
        end
    end

    assign DMACK_n     = dmack_n_q;
    assign STOP        = stop_q;
    assign HDMARDY_n   = hdmardy_n_q;
    assign IDE_r_en    = r_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign short_xfer  = short_q;
    assign err_timeout = err_q;
    assign words_done  = words_q;

endmodule
